// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_MWAIT = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MW = 2'b01;
  localparam logic [1:0] FWD_EM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: RAW detection, forwarding select,
// memory-wait / halt sequencing and saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W   = 3,
  parameter int FWD_EN  = 1,
  parameter int R0_ZERO = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_rs_used,
  input  logic             fd_rt_used,
  input  logic [REG_W-1:0] de_rs,
  input  logic [REG_W-1:0] de_rt,
  input  logic [REG_W-1:0] de_rd,
  input  logic             de_regwrite,
  input  logic             de_memread,
  input  logic [REG_W-1:0] em_rd,
  input  logic             em_regwrite,
  input  logic             em_memread,
  input  logic [REG_W-1:0] mw_rd,
  input  logic             mw_regwrite,
  input  logic             branch_taken,
  input  logic             dmem_stall,
  input  logic             mw_halt,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             fd_flush,
  output logic             de_nop,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic reg_match(input logic used, input logic we,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] rd);
    return used && we && (src == rd) && !((R0_ZERO != 0) && (rd == '0));
  endfunction

  // ---------------- data hazard ----------------
  logic rs_de, rt_de, rs_em, rt_em, haz;

  always_comb begin
    rs_de = reg_match(fd_rs_used, de_regwrite, fd_rs, de_rd);
    rt_de = reg_match(fd_rt_used, de_regwrite, fd_rt, de_rd);
    rs_em = reg_match(fd_rs_used, em_regwrite, fd_rs, em_rd);
    rt_em = reg_match(fd_rt_used, em_regwrite, fd_rt, em_rd);
    // Without forwarding every in-flight producer ahead of WB must drain.
    haz = (FWD_EN != 0) ? (de_memread && (rs_de || rt_de))
                        : (rs_de || rt_de || rs_em || rt_em);
  end

  // ---------------- forwarding ----------------
  logic [1:0][REG_W-1:0] ex_src;
  logic [1:0][1:0]       fwd_sel;

  assign ex_src = {de_rt, de_rs};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    always_comb begin
      fwd_sel[g] = FWD_RF;
      // A load in EX/MEM has no data yet, so it never sources a forward.
      if (reg_match(1'b1, em_regwrite && !em_memread, ex_src[g], em_rd))
        fwd_sel[g] = FWD_EM;
      else if (reg_match(1'b1, mw_regwrite, ex_src[g], mw_rd))
        fwd_sel[g] = FWD_MW;
      if ((FWD_EN == 0) || !rst)
        fwd_sel[g] = FWD_RF;
    end
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  // ---------------- control FSM ----------------
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_hold     = 1'b0;
    fd_hold     = 1'b0;
    fd_flush    = 1'b0;
    de_nop      = 1'b0;
    pipe_freeze = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      state_nxt = ST_RUN;
    end else if (state == ST_HALT) begin
      pc_hold     = 1'b1;
      fd_hold     = 1'b1;
      pipe_freeze = 1'b1;
      halted      = 1'b1;
    end else begin
      // RUN, STALL and MWAIT all re-evaluate the inputs from scratch.
      if (dmem_stall) begin
        pc_hold     = 1'b1;
        fd_hold     = 1'b1;
        pipe_freeze = 1'b1;
      end else if (haz) begin
        pc_hold = 1'b1;
        fd_hold = 1'b1;
        de_nop  = 1'b1;
      end else if (branch_taken) begin
        fd_flush = 1'b1;
      end

      if (mw_halt)         state_nxt = ST_HALT;
      else if (dmem_stall) state_nxt = ST_MWAIT;
      else if (haz)        state_nxt = ST_STALL;
      else                 state_nxt = ST_RUN;
    end
  end

  // ---------------- performance counters ----------------
  logic stall_inc;
  assign stall_inc = pc_hold && (state != ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (!rst),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (!rst),
    .inc   (fd_flush),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus
// multi-cycle sequences for stall, mem-wait, halt, reset and saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fd_rs, fd_rt, de_rs, de_rt, de_rd, em_rd, mw_rd;
  logic       fd_rs_used, fd_rt_used, de_regwrite, de_memread;
  logic       em_regwrite, em_memread, mw_regwrite;
  logic       branch_taken, dmem_stall, mw_halt;

  always #5 clk = ~clk;

  // u1: FWD_EN=1 baseline, ur: R0_ZERO=1, u0: FWD_EN=0, uc: CNT_W=4
  logic        ph1, fh1, ff1, dn1, pf1, hl1;
  logic [1:0]  fa1, fb1;
  logic [15:0] sc1, fc1;
  logic        phr, fhr, ffr, dnr, pfr, hlr;
  logic [1:0]  far, fbr;
  logic [15:0] scr, fcr;
  logic        ph0, fh0, ff0, dn0, pf0, hl0;
  logic [1:0]  fa0, fb0;
  logic [15:0] sc0, fc0;
  logic        phc, fhc, ffc, dnc, pfc, hlc;
  logic [1:0]  fac, fbc;
  logic [3:0]  scc, fcc;

  hazard_ctrl #(.REG_W(3), .FWD_EN(1), .R0_ZERO(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rs_used(fd_rs_used),
    .fd_rt_used(fd_rt_used), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd),
    .de_regwrite(de_regwrite), .de_memread(de_memread), .em_rd(em_rd),
    .em_regwrite(em_regwrite), .em_memread(em_memread), .mw_rd(mw_rd),
    .mw_regwrite(mw_regwrite), .branch_taken(branch_taken), .dmem_stall(dmem_stall),
    .mw_halt(mw_halt), .pc_hold(ph1), .fd_hold(fh1), .fd_flush(ff1), .de_nop(dn1),
    .pipe_freeze(pf1), .fwd_a(fa1), .fwd_b(fb1), .halted(hl1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_ctrl #(.REG_W(3), .FWD_EN(1), .R0_ZERO(1), .CNT_W(16)) ur (
    .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rs_used(fd_rs_used),
    .fd_rt_used(fd_rt_used), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd),
    .de_regwrite(de_regwrite), .de_memread(de_memread), .em_rd(em_rd),
    .em_regwrite(em_regwrite), .em_memread(em_memread), .mw_rd(mw_rd),
    .mw_regwrite(mw_regwrite), .branch_taken(branch_taken), .dmem_stall(dmem_stall),
    .mw_halt(mw_halt), .pc_hold(phr), .fd_hold(fhr), .fd_flush(ffr), .de_nop(dnr),
    .pipe_freeze(pfr), .fwd_a(far), .fwd_b(fbr), .halted(hlr),
    .stall_cnt(scr), .flush_cnt(fcr));

  hazard_ctrl #(.REG_W(3), .FWD_EN(0), .R0_ZERO(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rs_used(fd_rs_used),
    .fd_rt_used(fd_rt_used), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd),
    .de_regwrite(de_regwrite), .de_memread(de_memread), .em_rd(em_rd),
    .em_regwrite(em_regwrite), .em_memread(em_memread), .mw_rd(mw_rd),
    .mw_regwrite(mw_regwrite), .branch_taken(branch_taken), .dmem_stall(dmem_stall),
    .mw_halt(mw_halt), .pc_hold(ph0), .fd_hold(fh0), .fd_flush(ff0), .de_nop(dn0),
    .pipe_freeze(pf0), .fwd_a(fa0), .fwd_b(fb0), .halted(hl0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_ctrl #(.REG_W(3), .FWD_EN(1), .R0_ZERO(0), .CNT_W(4)) uc (
    .clk(clk), .rst(rst), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rs_used(fd_rs_used),
    .fd_rt_used(fd_rt_used), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd),
    .de_regwrite(de_regwrite), .de_memread(de_memread), .em_rd(em_rd),
    .em_regwrite(em_regwrite), .em_memread(em_memread), .mw_rd(mw_rd),
    .mw_regwrite(mw_regwrite), .branch_taken(branch_taken), .dmem_stall(dmem_stall),
    .mw_halt(mw_halt), .pc_hold(phc), .fd_hold(fhc), .fd_flush(ffc), .de_nop(dnc),
    .pipe_freeze(pfc), .fwd_a(fac), .fwd_b(fbc), .halted(hlc),
    .stall_cnt(scc), .flush_cnt(fcc));

  typedef struct {
    logic [2:0] fd_rs, fd_rt, de_rs, de_rt, de_rd, em_rd, mw_rd;
    logic       fd_rs_used, fd_rt_used, de_regwrite, de_memread;
    logic       em_regwrite, em_memread, mw_regwrite, branch_taken, dmem_stall;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    logic       hold, flush, nop, freeze;
    logic [1:0] fa, fb;
    logic       hold0;
    logic [1:0] fa_r0;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic in_t zin();
    in_t t;
    t = '{default: '0};
    return t;
  endfunction

  task automatic apply(input in_t t);
    fd_rs = t.fd_rs; fd_rt = t.fd_rt; de_rs = t.de_rs; de_rt = t.de_rt;
    de_rd = t.de_rd; em_rd = t.em_rd; mw_rd = t.mw_rd;
    fd_rs_used = t.fd_rs_used; fd_rt_used = t.fd_rt_used;
    de_regwrite = t.de_regwrite; de_memread = t.de_memread;
    em_regwrite = t.em_regwrite; em_memread = t.em_memread;
    mw_regwrite = t.mw_regwrite; branch_taken = t.branch_taken;
    dmem_stall = t.dmem_stall;
  endtask

  task automatic add(input string nm, input in_t t, input logic h, input logic f,
                     input logic n, input logic z, input logic [1:0] fa,
                     input logic [1:0] fb, input logic h0, input logic [1:0] far0);
    vec_t v;
    v.name = nm; v.i = t; v.hold = h; v.flush = f; v.nop = n; v.freeze = z;
    v.fa = fa; v.fb = fb; v.hold0 = h0; v.fa_r0 = far0;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; mw_halt = 1'b0; apply(zin());
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic in_t load_use();
    in_t t;
    t = zin();
    t.de_memread = 1'b1; t.de_regwrite = 1'b1; t.de_rd = 3'd2;
    t.fd_rs = 3'd2; t.fd_rs_used = 1'b1;
    return t;
  endfunction

  initial begin
    in_t t;

    // name, inputs, hold flush nop freeze fwd_a fwd_b | hold(FWD_EN=0) fwd_a(R0_ZERO=1)
    t = zin();                                 add("idle",        t, 0,0,0,0, 2'b00,2'b00, 0, 2'b00);
    t = load_use();                            add("ld_use_rs",   t, 1,0,1,0, 2'b00,2'b00, 1, 2'b00);
    t = load_use(); t.de_memread = 0;          add("alu_dep",     t, 0,0,0,0, 2'b00,2'b00, 1, 2'b00);
    t = load_use(); t.fd_rs_used = 0;          add("ld_unused",   t, 0,0,0,0, 2'b00,2'b00, 0, 2'b00);
    t = load_use(); t.fd_rs_used = 0; t.fd_rt = 3'd2; t.fd_rt_used = 1;
                                               add("ld_use_rt",   t, 1,0,1,0, 2'b00,2'b00, 1, 2'b00);
    t = zin(); t.de_rs = 3; t.em_rd = 3; t.em_regwrite = 1; t.mw_rd = 3; t.mw_regwrite = 1;
                                               add("fwd_em",      t, 0,0,0,0, 2'b10,2'b00, 0, 2'b10);
    t.em_regwrite = 0;                         add("fwd_mw",      t, 0,0,0,0, 2'b01,2'b00, 0, 2'b01);
    t.em_regwrite = 1; t.em_memread = 1;       add("fwd_em_load", t, 0,0,0,0, 2'b01,2'b00, 0, 2'b01);
    t = zin(); t.em_regwrite = 1;              add("fwd_r0",      t, 0,0,0,0, 2'b10,2'b10, 0, 2'b00);
    t = zin(); t.de_rt = 5; t.mw_rd = 5; t.mw_regwrite = 1; t.em_rd = 1; t.em_regwrite = 1;
                                               add("fwd_b_mw",    t, 0,0,0,0, 2'b00,2'b01, 0, 2'b00);
    t = zin(); t.branch_taken = 1;             add("branch",      t, 0,1,0,0, 2'b00,2'b00, 0, 2'b00);
    t = load_use(); t.branch_taken = 1;        add("br_haz",      t, 1,0,1,0, 2'b00,2'b00, 1, 2'b00);
    t = zin(); t.dmem_stall = 1; t.branch_taken = 1;
                                               add("dmem_br",     t, 1,0,0,1, 2'b00,2'b00, 1, 2'b00);
    t = load_use(); t.dmem_stall = 1;          add("dmem_haz",    t, 1,0,0,1, 2'b00,2'b00, 1, 2'b00);
    t = zin(); t.em_rd = 4; t.em_regwrite = 1; t.fd_rt = 4; t.fd_rt_used = 1;
                                               add("em_raw",      t, 0,0,0,0, 2'b00,2'b00, 1, 2'b00);
    t = zin(); t.mw_rd = 4; t.mw_regwrite = 1; t.fd_rt = 4; t.fd_rt_used = 1;
                                               add("mw_raw",      t, 0,0,0,0, 2'b00,2'b00, 0, 2'b00);

    // ---- reset state ----
    rst = 1'b0; mw_halt = 1'b0; apply(zin());
    repeat (2) @(negedge clk);
    #1;
    chk("rst_halted", hl1, 0);
    chk("rst_stall_cnt", sc1, 0);
    chk("rst_flush_cnt", fc1, 0);
    apply(load_use()); branch_taken = 1'b1;
    #1;
    chk("rst_gate_hold", ph1, 0);
    chk("rst_gate_flush", ff1, 0);
    @(negedge clk);
    rst = 1'b1; apply(zin());

    // ---- vector table ----
    foreach (vq[k]) begin
      @(negedge clk);
      apply(vq[k].i);
      #1;
      chk({vq[k].name, ".pc_hold"}, ph1, vq[k].hold);
      chk({vq[k].name, ".fd_hold"}, fh1, vq[k].hold);
      chk({vq[k].name, ".fd_flush"}, ff1, vq[k].flush);
      chk({vq[k].name, ".de_nop"}, dn1, vq[k].nop);
      chk({vq[k].name, ".pipe_freeze"}, pf1, vq[k].freeze);
      chk({vq[k].name, ".fwd_a"}, fa1, vq[k].fa);
      chk({vq[k].name, ".fwd_b"}, fb1, vq[k].fb);
      chk({vq[k].name, ".nofwd_hold"}, ph0, vq[k].hold0);
      chk({vq[k].name, ".nofwd_fwd_a"}, fa0, 2'b00);
      chk({vq[k].name, ".r0_fwd_a"}, far, vq[k].fa_r0);
    end

    // ---- load-use: exactly one stall cycle ----
    do_reset();
    apply(load_use());
    #1;
    chk("lu.hold_c0", ph1, 1);
    chk("lu.cnt_c0", sc1, 0);
    @(negedge clk);
    t = zin(); t.em_rd = 2; t.em_regwrite = 1; t.em_memread = 1; t.fd_rs = 2; t.fd_rs_used = 1;
    apply(t);
    #1;
    chk("lu.hold_c1", ph1, 0);
    chk("lu.nop_c1", dn1, 0);
    chk("lu.cnt_c1", sc1, 1);
    @(negedge clk); #1;
    chk("lu.cnt_c2", sc1, 1);

    // ---- FWD_EN=0: stall until the producer leaves EX/MEM ----
    do_reset();
    t = zin(); t.em_rd = 4; t.em_regwrite = 1; t.fd_rt = 4; t.fd_rt_used = 1;
    apply(t);
    #1; chk("nf.hold_c0", ph0, 1);
    @(negedge clk); #1; chk("nf.hold_c1", ph0, 1);
    @(negedge clk); em_regwrite = 1'b0;
    #1; chk("nf.hold_c2", ph0, 0);
    chk("nf.stall_cnt", sc0, 2);
    @(negedge clk); em_regwrite = 1'b1; fd_rt_used = 1'b0;
    #1; chk("nf.unused_hold", ph0, 0);

    // ---- mem wait beats a branch; branch flushes when memory returns ----
    do_reset();
    dmem_stall = 1'b1; branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("mw.freeze_c%0d", k), pf1, 1);
      chk($sformatf("mw.pc_hold_c%0d", k), ph1, 1);
      chk($sformatf("mw.flush_c%0d", k), ff1, 0);
    end
    @(negedge clk); dmem_stall = 1'b0;
    #1;
    chk("mw.flush_exit", ff1, 1);
    chk("mw.freeze_exit", pf1, 0);
    @(negedge clk); branch_taken = 1'b0;
    #1;
    chk("mw.stall_cnt", sc1, 3);
    chk("mw.flush_cnt", fc1, 1);

    // ---- halt is sticky; reset clears it ----
    do_reset();
    dmem_stall = 1'b1;
    repeat (2) @(negedge clk);
    dmem_stall = 1'b0; mw_halt = 1'b1;
    #1; chk("hl.halted_c0", hl1, 0);
    @(negedge clk);
    mw_halt = 1'b0; apply(load_use()); branch_taken = 1'b1;
    #1;
    chk("hl.halted_c1", hl1, 1);
    chk("hl.pc_hold", ph1, 1);
    chk("hl.freeze", pf1, 1);
    chk("hl.flush", ff1, 0);
    chk("hl.nop", dn1, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("hl.halted_c4", hl1, 1);
    chk("hl.stall_cnt", sc1, 2);
    chk("hl.flush_cnt", fc1, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("hl.rst_halted", hl1, 0);
    chk("hl.rst_hold", ph1, 0);
    @(negedge clk); rst = 1'b1; apply(zin());
    #1;
    chk("hl.post_halted", hl1, 0);
    chk("hl.post_hold", ph1, 0);
    chk("hl.post_stall_cnt", sc1, 0);

    // ---- counter saturation ----
    do_reset();
    dmem_stall = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat.cnt4", scc, 15);
    chk("sat.cnt16", sc1, 20);
    dmem_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
